arb_rr_mux: RTL and testbench
=============================

// Module: arb_rr_mux
// PURPOSE
//  Round-robin arbiter sharing one mux_bin_tree datapath among WIDTH valid/ready streams.
//  Each cycle it picks one valid requester by rotating priority and drives the tree's binary select.
//  The selected word is captured in a one-deep output register.
//  Sits between parallel producers and a single consumer: 1-cycle latency, full throughput.
// PARAMETERS
//  DAT_T           logic [8-1:0]  data word type
//  WIDTH           4              requester count; power of 2, >=2, multiple of SPLIT
//  SPLIT           2              mux tree radix, passed to mux_bin_tree
//  IMPLEMENTATION  0              mux tree implementation select, passed through
//  WIDTH_LOG       $clog2(WIDTH)  localparam, grant index width
// PORTS
//  clk      in   1          clock, rising edge
//  rst      in   1          reset, asynchronous, active-high
//  req_vld  in   WIDTH      per-requester valid
//  req_lst  in   WIDTH      per-requester last-beat flag (used only with lock feature)
//  req_dat  in   DAT_T[W]   per-requester data array [WIDTH-1:0]
//  req_rdy  out  WIDTH      per-requester ready; at most one bit set
//  out_vld  out  1          output valid (registered)
//  out_rdy  in   1          output ready from consumer
//  out_dat  out  DAT_T      output data (registered)
//  out_bin  out  WIDTH_LOG  index of requester that produced out_dat (registered)
// BEHAVIOUR
//  - Reset: out_vld=0, out_dat='0, out_bin=0, ptr=0, lock=0. Async assert; deassert synced by user.
//  - Output register load: ld = ~out_vld | out_rdy. Transfer on req side: req_vld[g] & req_rdy[g].
//  - Grant g: first i in order ptr, ptr+1, ..., ptr+WIDTH-1 (mod WIDTH) with req_vld[i]=1.
//    Combinational from req_vld and ptr. gnt_any = |req_vld.
//  - req_rdy[i] = ld & gnt_any & (i==g). Never depends on req_vld[j] for j!=i beyond priority.
//  - On ld: out_vld<=gnt_any. If gnt_any: out_dat<=req_dat[g] (via mux_bin_tree, bin=g),
//    out_bin<=g, ptr<=g+1 (wraps WIDTH-1 -> 0). If ~gnt_any: ptr, out_dat and out_bin hold.
//  - Stall (out_vld & ~out_rdy): all req_rdy=0, output regs and ptr hold; out_dat stable.
//  - Latency: req accepted in cycle n -> out_vld in cycle n+1. Throughput 1 word/cycle.
//  - Fairness: a continuously valid requester is granted within WIDTH transfers.
//  - Simultaneous out_rdy and new grant: old word leaves and new word loads in the same edge.
//  - Reset mid-transfer: pending out word discarded; no req_rdy during rst.
// CONFIGURATION
//  ARB_RR_MUX_LOCK_EN defined: packet lock.
//   - Lock sets on a transfer from g with req_lst[g]=0 and clears on a transfer with req_lst[g]=1.
//   - While locked, g is forced to the locked index and ptr is frozen. If that requester's
//     req_vld=0, gnt_any=0 and no other requester is granted (output bubble).
//   - ptr advances to g+1 only on the last-beat transfer.
//  ARB_RR_MUX_LOCK_EN undefined: req_lst ignored; every beat re-arbitrates; no lock reg.
// STRUCTURE
//  - Package arb_pkg: function rr_next(ptr, WIDTH) for wrap increment.
//    The grant index type is the WIDTH_LOG-wide vector.
//  - Sub-module pri_rr: rotating priority encoder.
//    req[WIDTH] and ptr -> bin[WIDTH_LOG] and vld; purely combinational.
//  - mux_bin_tree selects req_dat by g. Top holds ptr, lock and output registers.
// TESTING  (WIDTH=4, DAT_T=8 bit, dat_i = 8'h10+i)
//  1 reset: rst=1 with all req_vld=1 -> out_vld=0, req_rdy=0000, out_bin=0.
//  2 all valid, out_rdy=1, 8 cycles -> out_bin 0,1,2,3,0,1,2,3; out_dat 10,11,12,13,...
//  3 req_vld=0100 only, ptr=0 -> g=2, out_bin=2, out_dat=8'h12, ptr->3.
//    Then req_vld=0001 -> g=0 (wrap).
//  4 backpressure: out_rdy=0 for 3 cycles with word 8'h11 pending -> req_rdy=0000,
//    out_dat held at 8'h11; out_rdy=1 -> next word loads the same edge.
//  5 LOCK_EN: req 1 sends 3 beats lst=0,0,1 while req 0,2,3 are valid.
//    -> out_bin=1,1,1, then 2; with req_vld[1] dropped mid-packet -> out_vld=0 bubble.
//  6 rst asserted while out_vld=1 & out_rdy=0 -> out_vld=0 immediately, ptr=0, lock cleared.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin arbiter slice.
package arb_pkg;

  // Wrap-around increment of a requester index.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned width);
    return (ptr == width - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/mux_bin_tree.sv
// Binary-select mux: radix-SPLIT tree (IMPLEMENTATION 0) or a flat index.
// SPLIT must be a power of 2; unused leaves of a ragged tree read as zero.
module mux_bin_tree #(
  parameter  type DAT_T          = logic [7:0],
  parameter  int  WIDTH          = 4,
  parameter  int  SPLIT          = 2,
  parameter  int  IMPLEMENTATION = 0,
  localparam int  WIDTH_LOG      = $clog2(WIDTH)
) (
  input  DAT_T [WIDTH-1:0]     ary,
  input  logic [WIDTH_LOG-1:0] bin,
  output DAT_T                 out
);

  if (IMPLEMENTATION == 0) begin : g_tree
    localparam int SL  = $clog2(SPLIT);
    localparam int LVL = (WIDTH_LOG + SL - 1) / SL;
    localparam int PAD = 1 << (LVL * SL);

    logic [LVL*SL-1:0] sel;
    assign sel = (LVL*SL)'(bin);

    // Level 0 holds the leaves; each level up consumes one SL-bit digit of sel.
    for (genvar k = 0; k <= LVL; k++) begin : g_lvl
      localparam int N = PAD >> (k * SL);
      DAT_T node [N];
      if (k == 0) begin : g_leaf
        for (genvar j = 0; j < N; j++) begin : g_j
          if (j < WIDTH) begin : g_in
            assign node[j] = ary[j];
          end else begin : g_pad
            assign node[j] = '0;
          end
        end
      end else begin : g_mux
        localparam int IW = $clog2(N * SPLIT);
        for (genvar j = 0; j < N; j++) begin : g_j
          logic [IW-1:0] idx;
          assign idx     = IW'(j * SPLIT) | IW'(sel[(k-1)*SL +: SL]);
          assign node[j] = g_lvl[k-1].node[idx];
        end
      end
    end

    assign out = g_lvl[LVL].node[0];
  end else begin : g_flat
    assign out = ary[bin];
  end

endmodule

// File: rtl/pri_rr.sv
// Rotating priority encoder: first set req bit at or after ptr, wrapping.
module pri_rr #(
  parameter  int WIDTH     = 4,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     req,
  input  logic [WIDTH_LOG-1:0] ptr,
  output logic [WIDTH_LOG-1:0] bin,
  output logic                 vld
);

  // Walk from the lowest priority upward so the last hit is the winner.
  // WIDTH is a power of 2, so the index sum wraps for free.
  always_comb begin
    bin = '0;
    vld = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[ptr + WIDTH_LOG'(i)]) begin
        bin = ptr + WIDTH_LOG'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_rr_mux.sv
// Round-robin arbiter feeding one mux_bin_tree into a one-deep output register.
// Define ARB_RR_MUX_LOCK_EN to hold the grant for a whole packet (req_lst marks the last beat).
module arb_rr_mux
  import arb_pkg::*;
#(
  parameter  type DAT_T          = logic [8-1:0],
  parameter  int  WIDTH          = 4,
  parameter  int  SPLIT          = 2,
  parameter  int  IMPLEMENTATION = 0,
  localparam int  WIDTH_LOG      = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req_vld,
  input  logic [WIDTH-1:0]     req_lst,
  input  DAT_T [WIDTH-1:0]     req_dat,
  output logic [WIDTH-1:0]     req_rdy,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output DAT_T                 out_dat,
  output logic [WIDTH_LOG-1:0] out_bin
);

  typedef logic [WIDTH_LOG-1:0] bin_t;

  bin_t ptr_q, ptr_d, rr_bin, g;
  bin_t out_bin_q, out_bin_d;
  DAT_T out_dat_q, out_dat_d, mux_dat;
  logic out_vld_q, out_vld_d;
  logic rr_vld, gnt_any, ld, xfer;

  pri_rr #(.WIDTH(WIDTH)) u_pri (
    .req (req_vld),
    .ptr (ptr_q),
    .bin (rr_bin),
    .vld (rr_vld)
  );

`ifdef ARB_RR_MUX_LOCK_EN
  logic lock_q, lock_d;
  bin_t lock_bin_q, lock_bin_d;

  // A locked requester that drops valid yields a bubble, never another grant.
  assign g       = lock_q ? lock_bin_q : rr_bin;
  assign gnt_any = lock_q ? req_vld[lock_bin_q] : rr_vld;
`else
  logic unused_lst;
  assign unused_lst = ^req_lst;
  assign g          = rr_bin;
  assign gnt_any    = rr_vld;
`endif

  mux_bin_tree #(
    .DAT_T          (DAT_T),
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_mux (
    .ary (req_dat),
    .bin (g),
    .out (mux_dat)
  );

  assign ld   = ~out_vld_q | out_rdy;
  assign xfer = ld & gnt_any & ~rst;

  always_comb begin
    req_rdy = '0;
    if (xfer) req_rdy[g] = 1'b1;
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_bin_d = out_bin_q;
    ptr_d     = ptr_q;
`ifdef ARB_RR_MUX_LOCK_EN
    lock_d     = lock_q;
    lock_bin_d = lock_bin_q;
`endif
    if (ld) out_vld_d = gnt_any;
    if (xfer) begin
      out_dat_d = mux_dat;
      out_bin_d = g;
`ifdef ARB_RR_MUX_LOCK_EN
      if (req_lst[g]) begin
        lock_d = 1'b0;
        ptr_d  = bin_t'(rr_next(32'(g), WIDTH));
      end else begin
        lock_d     = 1'b1;
        lock_bin_d = g;
      end
`else
      ptr_d = bin_t'(rr_next(32'(g), WIDTH));
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_bin_q  <= '0;
      ptr_q      <= '0;
`ifdef ARB_RR_MUX_LOCK_EN
      lock_q     <= 1'b0;
      lock_bin_q <= '0;
`endif
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_bin_q  <= out_bin_d;
      ptr_q      <= ptr_d;
`ifdef ARB_RR_MUX_LOCK_EN
      lock_q     <= lock_d;
      lock_bin_q <= lock_bin_d;
`endif
    end
  end

  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;
  assign out_bin = out_bin_q;

endmodule

// File: tb/tb_arb_rr_mux.sv
// Scoreboard bench for arb_rr_mux (WIDTH=4, 8-bit data, requester i drives 8'h10+i).
module tb_arb_rr_mux;

  typedef struct packed {
    logic [1:0] bin;
    logic [7:0] dat;
  } exp_t;

  logic            clk, rst;
  logic [3:0]      req_vld, req_lst, req_rdy;
  logic [3:0][7:0] req_dat;
  logic            out_vld, out_rdy;
  logic [7:0]      out_dat;
  logic [1:0]      out_bin;

  exp_t sb[$];
  exp_t e;
  int   total, passed;

  arb_rr_mux #(
    .DAT_T          (logic [7:0]),
    .WIDTH          (4),
    .SPLIT          (2),
    .IMPLEMENTATION (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_lst (req_lst),
    .req_dat (req_dat),
    .req_rdy (req_rdy),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_dat (out_dat),
    .out_bin (out_bin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; req_vld = 4'hF; req_lst = 4'hF; out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (out_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", out_vld); else passed++;
    total++; if (req_rdy !== 4'b0000) $display("FAIL reset_rdy got=%b exp=0000", req_rdy); else passed++;
    total++; if (out_bin !== 2'd0) $display("FAIL reset_bin got=%0d exp=0", out_bin); else passed++;
    total++; if (out_dat !== 8'h00) $display("FAIL reset_dat got=%h exp=00", out_dat); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ptr starts at 0: grants rotate 0,1,2,3,0,1,2,3.
  task automatic test_all_valid();
    req_vld = 4'hF; req_lst = 4'hF; out_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      total++; if (req_rdy !== 4'(1 << (c % 4)))
        $display("FAIL all_rdy c=%0d got=%b exp=%b", c, req_rdy, 4'(1 << (c % 4))); else passed++;
      sb.push_back('{bin: 2'(c % 4), dat: 8'h10 + 8'(c % 4)});
      @(negedge clk);
      e = sb.pop_front();
      total++; if (out_vld !== 1'b1 || out_bin !== e.bin || out_dat !== e.dat)
        $display("FAIL all_out c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, out_vld, out_bin, out_dat, e.bin, e.dat);
      else passed++;
    end
    req_vld = 4'h0;
    @(negedge clk);
    total++; if (out_vld !== 1'b0) $display("FAIL all_drain got=%b exp=0", out_vld); else passed++;
  endtask

  // ptr=0, only req 2 valid -> 2; then only req 0 -> wraps from ptr=3.
  task automatic test_single_wrap();
    logic [3:0] vv [2];
    exp_t       ee [2];
    vv[0] = 4'b0100; ee[0] = '{bin: 2'd2, dat: 8'h12};
    vv[1] = 4'b0001; ee[1] = '{bin: 2'd0, dat: 8'h10};
    for (int c = 0; c < 2; c++) begin
      req_vld = vv[c];
      #1;
      total++; if (req_rdy !== vv[c]) $display("FAIL wrap_rdy c=%0d got=%b exp=%b", c, req_rdy, vv[c]); else passed++;
      sb.push_back(ee[c]);
      @(negedge clk);
      e = sb.pop_front();
      total++; if (out_vld !== 1'b1 || out_bin !== e.bin || out_dat !== e.dat)
        $display("FAIL wrap_out c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, out_vld, out_bin, out_dat, e.bin, e.dat);
      else passed++;
    end
    req_vld = 4'h0;
    @(negedge clk);
  endtask

  // ptr=1: word 8'h11 is stalled 3 cycles, then leaves as 8'h12 loads on the same edge.
  task automatic test_backpressure();
    req_vld = 4'hF; req_lst = 4'hF; out_rdy = 1'b1;
    #1;
    total++; if (req_rdy !== 4'b0010) $display("FAIL bp_first_rdy got=%b exp=0010", req_rdy); else passed++;
    sb.push_back('{bin: 2'd1, dat: 8'h11});
    @(negedge clk);
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (req_rdy !== 4'b0000) $display("FAIL bp_stall_rdy k=%0d got=%b exp=0000", k, req_rdy); else passed++;
      total++; if (out_vld !== 1'b1 || out_dat !== sb[0].dat || out_bin !== sb[0].bin)
        $display("FAIL bp_hold k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, out_vld, out_bin, out_dat, sb[0].bin, sb[0].dat);
      else passed++;
      @(negedge clk);
    end
    out_rdy = 1'b1;
    #1;
    total++; if (req_rdy !== 4'b0100) $display("FAIL bp_resume_rdy got=%b exp=0100", req_rdy); else passed++;
    e = sb.pop_front();
    sb.push_back('{bin: 2'd2, dat: 8'h12});
    @(negedge clk);
    e = sb.pop_front();
    total++; if (out_vld !== 1'b1 || out_bin !== e.bin || out_dat !== e.dat)
      $display("FAIL bp_next got=%b/%0d/%h exp=1/%0d/%h", out_vld, out_bin, out_dat, e.bin, e.dat);
    else passed++;
    req_vld = 4'h0;
    @(negedge clk);
  endtask

`ifdef ARB_RR_MUX_LOCK_EN
  // ptr=3. Steps: move ptr to 1, 3-beat packet from req 1, then req 2,
  // then a packet on req 3 that stalls when req 3 drops valid.
  task automatic test_lock();
    logic [3:0] vv [8], ll [8], rr [8];
    exp_t       ee [8];
    logic       bub [8];
    vv = '{4'b0001, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b0111, 4'hF};
    ll = '{4'hF, 4'b1101, 4'b1101, 4'hF, 4'hF, 4'b0111, 4'hF, 4'hF};
    rr = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b1000};
    ee = '{'{bin: 2'd0, dat: 8'h10}, '{bin: 2'd1, dat: 8'h11}, '{bin: 2'd1, dat: 8'h11},
           '{bin: 2'd1, dat: 8'h11}, '{bin: 2'd2, dat: 8'h12}, '{bin: 2'd3, dat: 8'h13},
           '{bin: 2'd0, dat: 8'h00}, '{bin: 2'd3, dat: 8'h13}};
    bub = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    out_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_vld = vv[c]; req_lst = ll[c];
      #1;
      total++; if (req_rdy !== rr[c]) $display("FAIL lock_rdy c=%0d got=%b exp=%b", c, req_rdy, rr[c]); else passed++;
      if (!bub[c]) sb.push_back(ee[c]);
      @(negedge clk);
      if (bub[c]) begin
        total++; if (out_vld !== 1'b0) $display("FAIL lock_bubble got=%b exp=0", out_vld); else passed++;
      end else begin
        e = sb.pop_front();
        total++; if (out_vld !== 1'b1 || out_bin !== e.bin || out_dat !== e.dat)
          $display("FAIL lock_out c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, out_vld, out_bin, out_dat, e.bin, e.dat);
        else passed++;
      end
    end
    req_vld = 4'h0; req_lst = 4'hF;
    @(negedge clk);
  endtask
`else
  // ptr=3: with lock disabled req_lst=0 must not hold the grant.
  task automatic test_no_lock();
    req_vld = 4'hF; req_lst = 4'h0; out_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (req_rdy !== 4'(1 << ((3 + c) % 4)))
        $display("FAIL nolock_rdy c=%0d got=%b exp=%b", c, req_rdy, 4'(1 << ((3 + c) % 4))); else passed++;
      sb.push_back('{bin: 2'((3 + c) % 4), dat: 8'h10 + 8'((3 + c) % 4)});
      @(negedge clk);
      e = sb.pop_front();
      total++; if (out_vld !== 1'b1 || out_bin !== e.bin || out_dat !== e.dat)
        $display("FAIL nolock_out c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, out_vld, out_bin, out_dat, e.bin, e.dat);
      else passed++;
    end
    req_vld = 4'h0; req_lst = 4'hF;
    @(negedge clk);
  endtask
`endif

  // Stalled word (req 2, lst=0 so a lock build is locked on 2) is discarded by reset.
  task automatic test_reset_mid();
    req_vld = 4'b0100; req_lst = 4'h0; out_rdy = 1'b0;
    #1;
    total++; if (req_rdy !== 4'b0100) $display("FAIL rmid_rdy got=%b exp=0100", req_rdy); else passed++;
    @(negedge clk);
    req_vld = 4'hF;
    #1;
    total++; if (out_vld !== 1'b1 || out_dat !== 8'h12) $display("FAIL rmid_pend got=%b/%h exp=1/12", out_vld, out_dat); else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if (out_vld !== 1'b0) $display("FAIL rmid_vld got=%b exp=0", out_vld); else passed++;
    total++; if (out_dat !== 8'h00 || out_bin !== 2'd0) $display("FAIL rmid_regs got=%h/%0d exp=00/0", out_dat, out_bin); else passed++;
    total++; if (req_rdy !== 4'b0000) $display("FAIL rmid_rdy_rst got=%b exp=0000", req_rdy); else passed++;
    sb.delete();
    @(negedge clk);
    rst = 1'b0; out_rdy = 1'b1; req_lst = 4'hF;
    #1;
    total++; if (req_rdy !== 4'b0001) $display("FAIL rmid_ptr got=%b exp=0001", req_rdy); else passed++;
    sb.push_back('{bin: 2'd0, dat: 8'h10});
    @(negedge clk);
    e = sb.pop_front();
    total++; if (out_vld !== 1'b1 || out_bin !== e.bin || out_dat !== e.dat)
      $display("FAIL rmid_out got=%b/%0d/%h exp=1/%0d/%h", out_vld, out_bin, out_dat, e.bin, e.dat);
    else passed++;
    req_vld = 4'h0;
    @(negedge clk);
  endtask

  initial begin
    total = 0; passed = 0;
    rst = 1'b1; out_rdy = 1'b0; req_vld = 4'h0; req_lst = 4'h0;
    for (int i = 0; i < 4; i++) req_dat[i] = 8'h10 + 8'(i);
    test_reset();
    test_all_valid();
    test_single_wrap();
    test_backpressure();
`ifdef ARB_RR_MUX_LOCK_EN
    test_lock();
`else
    test_no_lock();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
